// File: rtl/cmult_share_ctrl.sv
// rtl/cmult_share_ctrl.sv - round-robin sharing of one pipelined complex multiplier
// Grants one operand set per cycle, tags it through the multiplier latency, stalls on back-pressure.
module cmult_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int N       = 18,
  parameter int INR     = 0,
  parameter int OUTR    = 1,
  parameter int PIPER   = 0,
  localparam int LAT    = INR + OUTR + PIPER,
  localparam int MUL_W  = (N <= 9) ? 9 : (N <= 18) ? 18 : 36,
  localparam int RW     = 2 * MUL_W + 1,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_real1,
  input  logic [NUM_REQ*N-1:0] req_imag1,
  input  logic [NUM_REQ*N-1:0] req_real2,
  input  logic [NUM_REQ*N-1:0] req_imag2,
  output logic                 mul_reset,
  output logic                 mul_ce,
  output logic [N-1:0]         mul_real1,
  output logic [N-1:0]         mul_imag1,
  output logic [N-1:0]         mul_real2,
  output logic [N-1:0]         mul_imag2,
  input  logic [RW-1:0]        mul_realo,
  input  logic [RW-1:0]        mul_imago,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [RW-1:0]        res_real,
  output logic [RW-1:0]        res_imag
);

  if (LAT < 1 || LAT > 3) begin : g_bad_lat
    $error("cmult_share_ctrl: INR+OUTR+PIPER must be in 1..3");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("cmult_share_ctrl: NUM_REQ must be in 2..8");
  end
  if (INR > 1 || OUTR > 1 || PIPER > 1 || INR < 0 || OUTR < 0 || PIPER < 0) begin : g_bad_stage
    $error("cmult_share_ctrl: INR, OUTR and PIPER must each be 0 or 1");
  end

  logic               adv;
  logic [IDW-1:0]     last;
  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic [IDW:0]       cand;
  logic [LAT-1:0]     tag_v;
  logic [IDW-1:0]     tag_id [LAT];

  assign adv       = ~res_valid | res_ready;
  assign mul_ce    = adv & ~reset;
  assign mul_reset = reset;

  assign res_valid = tag_v[LAT-1];
  assign res_id    = tag_id[LAT-1];
  assign res_real  = mul_realo;
  assign res_imag  = mul_imago;

  // Search starts just after the last winner; cand has one spare bit so last+k never overflows.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (mul_ce && !grant_any && req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Ungranted cycles feed zeros so the multiplier sees clean bubbles.
  always_comb begin
    mul_real1 = '0;
    mul_imag1 = '0;
    mul_real2 = '0;
    mul_imag2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_real1 = req_real1[i*N +: N];
        mul_imag1 = req_imag1[i*N +: N];
        mul_real2 = req_real2[i*N +: N];
        mul_imag2 = req_imag2[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last  <= IDW'(NUM_REQ - 1);
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else if (adv) begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      if (grant_any) begin
        last <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_cmult_share_ctrl.sv
// tb/tb_cmult_share_ctrl.sv - scoreboard bench for cmult_share_ctrl
// Two instances: LAT=1 (default stages) with a cycle model, and LAT=3 for latency/reset cases.
`timescale 1ns/1ps
module tb_cmult_share_ctrl;

  localparam int NR = 4;
  localparam int N  = 18;
  localparam int RW = 37;
  localparam int LA = 1;
  localparam logic signed [N-1:0] MINV = 18'sh20000;
  localparam logic signed [N-1:0] MAXV = 18'sh1ffff;

  typedef struct { int id; longint re; longint im; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A (LAT=1) ----------------
  logic [NR-1:0]   a_valid, a_ready;
  logic [NR*N-1:0] a_r1f, a_i1f, a_r2f, a_i2f;
  logic            a_mreset, a_ce;
  logic [N-1:0]    a_mr1, a_mi1, a_mr2, a_mi2;
  logic [RW-1:0]   a_mro, a_mio;
  logic            a_res_valid;
  logic            a_res_ready = 1'b1;
  logic [1:0]      a_res_id;
  logic [RW-1:0]   a_res_real, a_res_imag;

  // ---------------- instance B (LAT=3) ----------------
  logic [NR-1:0]   b_valid = '0;
  logic [NR-1:0]   b_ready;
  logic [NR*N-1:0] b_r1f = '0, b_i1f = '0, b_r2f = '0, b_i2f = '0;
  logic            b_mreset, b_ce;
  logic [N-1:0]    b_mr1, b_mi1, b_mr2, b_mi2;
  logic [RW-1:0]   b_mro, b_mio;
  logic            b_res_valid;
  logic            b_res_ready = 1'b1;
  logic [1:0]      b_res_id;
  logic [RW-1:0]   b_res_real, b_res_imag;

  cmult_share_ctrl #(.NUM_REQ(NR), .N(N), .INR(0), .OUTR(1), .PIPER(0)) dut_a (
    .clk(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_real1(a_r1f), .req_imag1(a_i1f), .req_real2(a_r2f), .req_imag2(a_i2f),
    .mul_reset(a_mreset), .mul_ce(a_ce),
    .mul_real1(a_mr1), .mul_imag1(a_mi1), .mul_real2(a_mr2), .mul_imag2(a_mi2),
    .mul_realo(a_mro), .mul_imago(a_mio),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_id(a_res_id),
    .res_real(a_res_real), .res_imag(a_res_imag));

  cmult_share_ctrl #(.NUM_REQ(NR), .N(N), .INR(1), .OUTR(1), .PIPER(1)) dut_b (
    .clk(clk), .reset(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_real1(b_r1f), .req_imag1(b_i1f), .req_real2(b_r2f), .req_imag2(b_i2f),
    .mul_reset(b_mreset), .mul_ce(b_ce),
    .mul_real1(b_mr1), .mul_imag1(b_mi1), .mul_real2(b_mr2), .mul_imag2(b_mi2),
    .mul_realo(b_mro), .mul_imago(b_mio),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_id(b_res_id),
    .res_real(b_res_real), .res_imag(b_res_imag));

  function automatic longint cre(input logic signed [N-1:0] r1, input logic signed [N-1:0] i1,
                                 input logic signed [N-1:0] r2, input logic signed [N-1:0] i2);
    return longint'(r1) * longint'(r2) - longint'(i1) * longint'(i2);
  endfunction

  function automatic longint cim(input logic signed [N-1:0] r1, input logic signed [N-1:0] i1,
                                 input logic signed [N-1:0] r2, input logic signed [N-1:0] i2);
    return longint'(r1) * longint'(i2) + longint'(r2) * longint'(i1);
  endfunction

  function automatic logic signed [N-1:0] pat(input int i, input int n, input int w);
    int h;
    h = (i * 977 + n * 7919 + w * 104729 + 12345) * 1103515245;
    if (((n + w) % 7) == 3) return MINV;
    if (((n + 2 * w) % 11) == 5) return MAXV;
    return N'(h >>> 9);
  endfunction

  // Multiplier models: functional product, LAT register stages with ce and reset.
  logic [RW-1:0] a_pre, a_pim;
  always @(posedge clk) begin
    if (a_mreset) begin
      a_pre <= '0;
      a_pim <= '0;
    end else if (a_ce) begin
      a_pre <= RW'(cre(a_mr1, a_mi1, a_mr2, a_mi2));
      a_pim <= RW'(cim(a_mr1, a_mi1, a_mr2, a_mi2));
    end
  end
  assign a_mro = a_pre;
  assign a_mio = a_pim;

  logic [RW-1:0] b_pre [3];
  logic [RW-1:0] b_pim [3];
  always @(posedge clk) begin
    if (b_mreset) begin
      for (int k = 0; k < 3; k++) begin
        b_pre[k] <= '0;
        b_pim[k] <= '0;
      end
    end else if (b_ce) begin
      b_pre[0] <= RW'(cre(b_mr1, b_mi1, b_mr2, b_mi2));
      b_pim[0] <= RW'(cim(b_mr1, b_mi1, b_mr2, b_mi2));
      for (int k = 1; k < 3; k++) begin
        b_pre[k] <= b_pre[k-1];
        b_pim[k] <= b_pim[k-1];
      end
    end
  end
  assign b_mro = b_pre[2];
  assign b_mio = b_pim[2];

  // Requesters of A: requester i offers operand sets while issued[i] != target[i].
  int issued [NR];
  int target [NR];
  logic [NR-1:0] en = '1;
  logic [NR-1:0] fix_en = '0;
  logic signed [N-1:0] fix_r1 [NR], fix_i1 [NR], fix_r2 [NR], fix_i2 [NR];
  logic signed [N-1:0] op_r1 [NR], op_i1 [NR], op_r2 [NR], op_i2 [NR];

  always_comb begin
    a_valid = '0;
    a_r1f = '0;
    a_i1f = '0;
    a_r2f = '0;
    a_i2f = '0;
    for (int i = 0; i < NR; i++) begin
      op_r1[i] = fix_en[i] ? fix_r1[i] : pat(i, issued[i], 0);
      op_i1[i] = fix_en[i] ? fix_i1[i] : pat(i, issued[i], 1);
      op_r2[i] = fix_en[i] ? fix_r2[i] : pat(i, issued[i], 2);
      op_i2[i] = fix_en[i] ? fix_i2[i] : pat(i, issued[i], 3);
      a_valid[i] = en[i] && (issued[i] != target[i]);
      a_r1f[i*N +: N] = op_r1[i];
      a_i1f[i*N +: N] = op_i1[i];
      a_r2f[i*N +: N] = op_r2[i];
      a_i2f[i*N +: N] = op_i2[i];
    end
  end

  // Reference state for A.
  exp_t          sbq [$];
  logic [NR-1:0] gmask = '0;
  int            m_last = NR - 1;
  logic [LA-1:0] m_v = '0;
  int            m_popped = 0;
  logic          m_prev_stall = 1'b0;
  logic [1:0]    prev_id;
  logic [RW-1:0] prev_real, prev_imag;
  logic [NR-1:0] smp_ready, smp_b_ready;
  logic          smp_ce;

  task automatic monitor();
    logic          m_adv;
    int            g;
    logic [NR-1:0] exp_ready;
    exp_t          e;
    m_adv = !m_v[LA-1] || a_res_ready;
    g = -1;
    if (m_adv && !rst) begin
      for (int k = 1; k <= NR; k++) begin
        if (g < 0 && a_valid[(m_last + k) % NR]) g = (m_last + k) % NR;
      end
    end
    exp_ready = (g >= 0) ? (NR'(1) << g) : '0;

    n_checks++;
    if (a_res_valid !== m_v[LA-1]) begin
      n_errors++;
      $display("FAIL res_valid: got %b expected %b at %0t", a_res_valid, m_v[LA-1], $time);
    end
    n_checks++;
    if (a_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL req_ready: got %b expected %b at %0t", a_ready, exp_ready, $time);
    end
    n_checks++;
    if (a_ce !== (m_adv && !rst) || a_mreset !== rst) begin
      n_errors++;
      $display("FAIL mul_ce/mul_reset: got %b/%b expected %b/%b at %0t", a_ce, a_mreset, m_adv && !rst, rst, $time);
    end
    n_checks++;
    if (g >= 0) begin
      if ({a_mr1, a_mi1, a_mr2, a_mi2} !== {op_r1[g], op_i1[g], op_r2[g], op_i2[g]}) begin
        n_errors++;
        $display("FAIL operand_mux: got %h expected %h", {a_mr1, a_mi1, a_mr2, a_mi2}, {op_r1[g], op_i1[g], op_r2[g], op_i2[g]});
      end
    end else if ({a_mr1, a_mi1, a_mr2, a_mi2} !== '0) begin
      n_errors++;
      $display("FAIL operand_bubble: got %h expected 0", {a_mr1, a_mi1, a_mr2, a_mi2});
    end
    if (m_prev_stall) begin
      n_checks++;
      if ({a_res_id, a_res_real, a_res_imag} !== {prev_id, prev_real, prev_imag}) begin
        n_errors++;
        $display("FAIL stall_hold: got id %0d re %h im %h expected id %0d re %h im %h",
                 a_res_id, a_res_real, a_res_imag, prev_id, prev_real, prev_imag);
      end
    end
    if (m_v[LA-1] && a_res_ready) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty: got result id %0d expected none", a_res_id);
      end else begin
        e = sbq.pop_front();
        m_popped++;
        if (a_res_id !== 2'(e.id) || a_res_real !== RW'(e.re) || a_res_imag !== RW'(e.im)) begin
          n_errors++;
          $display("FAIL result: got id %0d re %0d im %0d expected id %0d re %0d im %0d",
                   a_res_id, $signed(a_res_real), $signed(a_res_imag), e.id, e.re, e.im);
        end
      end
    end
    m_prev_stall = m_v[LA-1] && !a_res_ready && !rst;
    prev_id   = a_res_id;
    prev_real = a_res_real;
    prev_imag = a_res_imag;

    gmask = exp_ready;
    if (rst) begin
      m_v    = '0;
      m_last = NR - 1;
      sbq.delete();
    end else if (m_adv) begin
      for (int k = LA - 1; k > 0; k--) m_v[k] = m_v[k-1];
      m_v[0] = (g >= 0);
      if (g >= 0) begin
        e.id = g;
        e.re = cre(op_r1[g], op_i1[g], op_r2[g], op_i2[g]);
        e.im = cim(op_r1[g], op_i1[g], op_r2[g], op_i2[g]);
        sbq.push_back(e);
        m_last = g;
      end
    end
  endtask

  // One clock: check at the falling edge, advance requesters just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    smp_ready   = a_ready;
    smp_ce      = a_ce;
    smp_b_ready = b_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (gmask[i]) issued[i]++;
  endtask

  function automatic logic pending();
    for (int i = 0; i < NR; i++) if (en[i] && issued[i] != target[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    a_res_ready = 1'b1;
    while ((sbq.size() != 0 || pending()) && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (sbq.size() != 0 || pending()) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d outstanding expected 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (a_res_valid !== 1'b0 || smp_ready !== '0 || smp_ce !== 1'b0 || a_mreset !== 1'b1 || b_res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got v%b rdy%b ce%b mrst%b bv%b expected v0 rdy0000 ce0 mrst1 bv0",
               a_res_valid, smp_ready, smp_ce, a_mreset, b_res_valid);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (a_res_valid !== 1'b0 || smp_ce !== 1'b1 || smp_ready !== '0) begin
      n_errors++;
      $display("FAIL reset_release: got v%b ce%b rdy%b expected v0 ce1 rdy0000", a_res_valid, smp_ce, smp_ready);
    end
  endtask

  task automatic test_single();
    fix_r1[0] = MINV; fix_i1[0] = '0; fix_r2[0] = MINV; fix_i2[0] = '0;
    fix_en[0] = 1'b1;
    target[0] = issued[0] + 1;
    tick();
    n_checks++;
    if (smp_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_grant: got %b expected 0001", smp_ready);
    end
    n_checks++;
    if (a_res_valid !== 1'b1 || a_res_id !== 2'd0 || a_res_real !== RW'(64'sd17179869184) || a_res_imag !== '0) begin
      n_errors++;
      $display("FAIL single_result: got v%b id %0d re %0d im %0d expected v1 id 0 re 17179869184 im 0",
               a_res_valid, a_res_id, $signed(a_res_real), $signed(a_res_imag));
    end
    tick();
    fix_en[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) target[i] = issued[i] + 2;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (smp_ready !== (NR'(1) << (k % NR)) || a_res_valid !== 1'b1 || a_res_id !== 2'(k % NR)) begin
        n_errors++;
        $display("FAIL rr_order_%0d: got rdy %b v%b id %0d expected rdy %b v1 id %0d",
                 k, smp_ready, a_res_valid, a_res_id, NR'(1) << (k % NR), k % NR);
      end
    end
    tick();
    n_checks++;
    if (smp_ready !== '0) begin
      n_errors++;
      $display("FAIL rr_done: got %b expected 0000", smp_ready);
    end
  endtask

  task automatic test_stall();
    logic [1:0]    st_id;
    logic [RW-1:0] st_re, st_im;
    int            popped0;
    popped0 = m_popped;
    for (int i = 0; i < NR; i++) target[i] = issued[i] + 6;
    tick();
    tick();
    a_res_ready = 1'b0;
    st_id = a_res_id;
    st_re = a_res_real;
    st_im = a_res_imag;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (smp_ce !== 1'b0 || smp_ready !== '0 || a_res_valid !== 1'b1 ||
          a_res_id !== st_id || a_res_real !== st_re || a_res_imag !== st_im) begin
        n_errors++;
        $display("FAIL stall_%0d: got ce%b rdy%b v%b id %0d expected ce0 rdy0000 v1 id %0d, held data",
                 k, smp_ce, smp_ready, a_res_valid, a_res_id, st_id);
      end
    end
    drain("stall");
    n_checks++;
    if (m_popped - popped0 != 24) begin
      n_errors++;
      $display("FAIL stall_count: got %0d results expected 24", m_popped - popped0);
    end
  endtask

  task automatic test_lat3();
    b_r1f[0 +: N] = MINV;
    b_i1f[0 +: N] = MINV;
    b_r2f[0 +: N] = MINV;
    b_i2f[0 +: N] = MAXV;
    b_valid = 4'b0001;
    tick();
    b_valid = '0;
    n_checks++;
    if (smp_b_ready !== 4'b0001 || b_res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL lat3_grant: got rdy %b v%b expected rdy 0001 v0", smp_b_ready, b_res_valid);
    end
    tick();
    n_checks++;
    if (b_res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL lat3_early: got v%b expected v0", b_res_valid);
    end
    tick();
    n_checks++;
    if (b_res_valid !== 1'b1 || b_res_id !== 2'd0 || b_res_real !== RW'(64'sd34359607296) ||
        b_res_imag !== RW'(cim(MINV, MINV, MINV, MAXV))) begin
      n_errors++;
      $display("FAIL lat3_result: got v%b id %0d re %0d im %0d expected v1 id 0 re 34359607296 im %0d",
               b_res_valid, b_res_id, $signed(b_res_real), $signed(b_res_imag), cim(MINV, MINV, MINV, MAXV));
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < NR; i++) begin
      b_r1f[i*N +: N] = N'(100 * (i + 1));
      b_i1f[i*N +: N] = N'(7 * (i + 1));
      b_r2f[i*N +: N] = N'(-3 * (i + 1));
      b_i2f[i*N +: N] = N'(11);
    end
    b_valid = 4'b0010;
    tick();
    b_valid = 4'b0001;
    tick();
    b_valid = '0;
    n_checks++;
    if (smp_b_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_pre_grant: got %b expected 0001", smp_b_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (b_res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_discard_%0d: got v%b expected v0", k, b_res_valid);
      end
      tick();
    end
    b_valid = 4'b0011;
    tick();
    b_valid = '0;
    n_checks++;
    if (smp_b_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_first_grant: got %b expected 0001", smp_b_ready);
    end
    tick();
    tick();
    n_checks++;
    if (b_res_valid !== 1'b1 || b_res_id !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_after_result: got v%b id %0d expected v1 id 0", b_res_valid, b_res_id);
    end
    tick();
  endtask

  task automatic test_skip_dropped();
    logic [NR-1:0] exp_seq [4];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b1000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    target[1] = issued[1] + 2;
    target[2] = issued[2] + 1;
    target[3] = issued[3] + 2;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) en[2] = 1'b0;
      n_checks++;
      if (k < 4 && smp_ready !== exp_seq[k]) begin
        n_errors++;
        $display("FAIL skip_seq_%0d: got %b expected %b", k, smp_ready, exp_seq[k]);
      end else if (a_res_valid === 1'b1 && a_res_id === 2'd2) begin
        n_errors++;
        $display("FAIL skip_id2_%0d: got id 2 expected no id 2", k);
      end
    end
    target[2] = issued[2];
    en[2] = 1'b1;
    drain("skip");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NR; i++) target[i] = issued[i] + 20;
    for (int k = 0; k < 80; k++) begin
      a_res_ready = ($urandom_range(0, 3) != 0);
      rst = (k == 40);
      tick();
    end
    rst = 1'b0;
    drain("b2b");
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      issued[i] = 0;
      target[i] = 0;
      fix_r1[i] = '0; fix_i1[i] = '0; fix_r2[i] = '0; fix_i2[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_lat3();
    test_reset_inflight();
    test_skip_dropped();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
